// File: rtl/exhaustive_vector_checker.sv
// Exhaustive stimulus generator and checker for an N-input combinational DUT.
// Walks every input vector in ascending order, samples f_dut on the last hold cycle, and tallies mismatches.
module exhaustive_vector_checker #(
   parameter int unsigned         N          = 3,
   parameter int unsigned         HOLD       = 4,
   parameter logic [(1<<N)-1:0]   EXPECTED   = 8'b1110_1000,
   parameter bit                  CONTINUOUS = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic         f_dut,
   output logic [N-1:0] vec,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic [N:0]   err_count,
   output logic         err_valid,
   output logic [N-1:0] first_err_vec
);

   localparam int unsigned CW = N + 1;
   localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
   localparam logic [N-1:0]  VEC_MAX   = '1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_APPLY = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [N-1:0]  vec_q, vec_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [CW-1:0] err_count_q, err_count_d;
   logic          err_valid_q, err_valid_d;
   logic [N-1:0]  first_err_vec_q, first_err_vec_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          pass_q, pass_d;

   logic          sample_c;
   logic          mismatch_c;
   logic [CW-1:0] err_next_c;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         vec_q           <= '0;
         hold_q          <= '0;
         err_count_q     <= '0;
         err_valid_q     <= 1'b0;
         first_err_vec_q <= '0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         pass_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         vec_q           <= vec_d;
         hold_q          <= hold_d;
         err_count_q     <= err_count_d;
         err_valid_q     <= err_valid_d;
         first_err_vec_q <= first_err_vec_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         pass_q          <= pass_d;
      end
   end

   // Next-state and output logic
   always_comb begin
      state_d         = state_q;
      vec_d           = vec_q;
      hold_d          = hold_q;
      err_count_d     = err_count_q;
      err_valid_d     = err_valid_q;
      first_err_vec_d = first_err_vec_q;
      busy_d          = busy_q;
      done_d          = done_q;
      pass_d          = pass_q;

      sample_c   = (state_q == ST_APPLY) && (hold_q == HOLD_LAST);
      mismatch_c = sample_c && (f_dut != EXPECTED[vec_q]);
      err_next_c = err_count_q + CW'(mismatch_c);

      if (abort) begin
         // Error registers deliberately survive an abort for post-mortem reading
         state_d = ST_IDLE;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         vec_d   = '0;
         hold_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_d         = ST_APPLY;
                  busy_d          = 1'b1;
                  done_d          = 1'b0;
                  pass_d          = 1'b0;
                  vec_d           = '0;
                  hold_d          = '0;
                  err_count_d     = '0;
                  err_valid_d     = 1'b0;
                  first_err_vec_d = '0;
               end
            end
            ST_APPLY: begin
               done_d = 1'b0;
               if (!sample_c) begin
                  hold_d = hold_q + HW'(1);
               end else begin
                  err_count_d = err_next_c;
                  if (mismatch_c && !err_valid_q) begin
                     err_valid_d     = 1'b1;
                     first_err_vec_d = vec_q;
                  end
                  hold_d = '0;
                  if (vec_q != VEC_MAX) begin
                     vec_d = vec_q + N'(1);
                  end else if (CONTINUOUS) begin
                     // Wrap: report this sweep, then begin the next one with clean counters
                     done_d          = 1'b1;
                     pass_d          = (err_next_c == '0);
                     vec_d           = '0;
                     err_count_d     = '0;
                     err_valid_d     = 1'b0;
                     first_err_vec_d = '0;
                  end else begin
                     state_d = ST_DONE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     pass_d  = (err_next_c == '0);
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b0;
               vec_d   = '0;
               hold_d  = '0;
            end
         endcase
      end
   end

   assign vec           = vec_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign err_count     = err_count_q;
   assign err_valid     = err_valid_q;
   assign first_err_vec = first_err_vec_q;

endmodule

// File: tb/tb_exhaustive_vector_checker.sv
// Bench for exhaustive_vector_checker: one-shot N=3/HOLD=4 instance and a continuous N=4/HOLD=1 parity instance,
// each driven by a truth-table DUT model and checked against set-theoretic expectations (mismatch sets of truth tables).
module tb_exhaustive_vector_checker;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Instance A: default parameters (3-input majority, one-shot)
   logic       start_a = 1'b0, abort_a = 1'b0, f_a;
   logic [2:0] vec_a, fv_a;
   logic       busy_a, done_a, pass_a, ev_a;
   logic [3:0] ec_a;
   logic [7:0] tt_a = 8'hE8;
   assign f_a = tt_a[vec_a];

   exhaustive_vector_checker u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .f_dut(f_a),
      .vec(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a),
      .err_count(ec_a), .err_valid(ev_a), .first_err_vec(fv_a)
   );

   // Instance B: 4-input parity, HOLD=1, continuous
   logic        start_b = 1'b0, abort_b = 1'b0, f_b;
   logic [3:0]  vec_b, fv_b;
   logic        busy_b, done_b, pass_b, ev_b;
   logic [4:0]  ec_b;
   logic [15:0] tt_b = 16'h6996;
   assign f_b = tt_b[vec_b];

   exhaustive_vector_checker #(
      .N(4), .HOLD(1), .EXPECTED(16'h6996), .CONTINUOUS(1'b1)
   ) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .f_dut(f_b),
      .vec(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b),
      .err_count(ec_b), .err_valid(ev_b), .first_err_vec(fv_b)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Number of mismatching vectors with index below lim
   function automatic int cnt_lt(input logic [15:0] d, input int lim);
      int c = 0;
      for (int i = 0; i < 16; i++) if (i < lim && d[i]) c++;
      return c;
   endfunction

   // Lowest mismatching vector below lim, 0 when none
   function automatic int first_lt(input logic [15:0] d, input int lim);
      for (int i = 0; i < 16; i++) if (i < lim && d[i]) return i;
      return 0;
   endfunction

   typedef struct {
      logic [7:0] tt;
      logic       poke;
      int         exp_cnt;
      int         exp_first;
      logic       exp_valid;
      logic       exp_pass;
   } rec_t;

   // One full one-shot sweep on instance A with per-cycle and end-of-sweep checks
   task automatic sweep_a(input rec_t r, input string nm);
      logic [15:0] d;
      int lim, c;
      d    = {8'h00, r.tt ^ 8'hE8};
      tt_a = r.tt;
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      for (int t = 1; t <= 32; t++) begin
         lim = (t - 1) / 4;
         c   = cnt_lt(d, lim);
         chk($sformatf("%s cyc%0d", nm, t),
             32'({busy_a, done_a, vec_a, ec_a, ev_a, fv_a}),
             32'({1'b1, 1'b0, 3'(lim), 4'(c), (c > 0), 3'(first_lt(d, lim))}));
         start_a = r.poke && (t == 10);
         @(negedge clk);
      end
      start_a = 1'b0;
      chk({nm, " end flags"}, 32'({busy_a, done_a, pass_a, vec_a}), 32'({1'b0, 1'b1, r.exp_pass, 3'd7}));
      chk({nm, " err_count"}, 32'(ec_a), 32'(r.exp_cnt));
      chk({nm, " err_valid"}, 32'(ev_a), 32'(r.exp_valid));
      chk({nm, " first_err"}, 32'(fv_a), 32'(r.exp_first));
      @(negedge clk);
      chk({nm, " done hold"}, 32'({busy_a, done_a, pass_a, vec_a}), 32'({1'b0, 1'b1, r.exp_pass, 3'd7}));
   endtask

   rec_t        tbl[7];
   logic [15:0] tt_seq[5];

   initial begin
      logic [15:0] d;
      int c, p, s;

      tbl[0] = '{8'hE8, 1'b0, 0, 0, 1'b0, 1'b1};
      tbl[1] = '{8'hFA, 1'b0, 2, 1, 1'b1, 1'b0};
      tbl[2] = '{8'h00, 1'b0, 4, 3, 1'b1, 1'b0};
      tbl[3] = '{8'hE8, 1'b1, 0, 0, 1'b0, 1'b1};
      tbl[4] = '{8'hFF, 1'b0, 4, 0, 1'b1, 1'b0};
      for (int i = 5; i < 7; i++) begin
         tbl[i].tt        = 8'($urandom);
         tbl[i].poke      = 1'b0;
         d                = {8'h00, tbl[i].tt ^ 8'hE8};
         tbl[i].exp_cnt   = cnt_lt(d, 8);
         tbl[i].exp_first = first_lt(d, 8);
         tbl[i].exp_valid = (tbl[i].exp_cnt > 0);
         tbl[i].exp_pass  = (tbl[i].exp_cnt == 0);
      end

      repeat (2) @(negedge clk);
      chk("reset A", 32'({vec_a, busy_a, done_a, pass_a, ec_a, ev_a, fv_a}), 32'd0);
      chk("reset B", 32'({vec_b, busy_b, done_b, pass_b, ec_b, ev_b, fv_b}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle A", 32'({vec_a, busy_a, done_a}), 32'd0);

      for (int i = 0; i < 7; i++) sweep_a(tbl[i], $sformatf("vec%0d", i));

      // Abort while vector 5 is applied; error registers survive
      tt_a = 8'h00;
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      repeat (20) @(negedge clk);
      chk("pre-abort vec", 32'(vec_a), 32'd5);
      abort_a = 1'b1;
      @(negedge clk) abort_a = 1'b0;
      chk("abort outputs", 32'({busy_a, done_a, vec_a}), 32'd0);
      chk("abort errs kept", 32'({ec_a, ev_a, fv_a}), 32'({4'd1, 1'b1, 3'd3}));
      repeat (3) @(negedge clk);
      chk("abort idle", 32'({busy_a, vec_a}), 32'd0);
      start_a = 1'b1;
      abort_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      abort_a = 1'b0;
      chk("abort beats start", 32'({busy_a, vec_a, ec_a}), 32'({1'b0, 3'd0, 4'd1}));
      @(negedge clk);
      chk("still idle", 32'({busy_a, vec_a}), 32'd0);
      sweep_a(tbl[0], "post-abort");

      // Asynchronous reset between clock edges mid-sweep
      tt_a = 8'h00;
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      repeat (13) @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("async rst A", 32'({vec_a, busy_a, done_a, pass_a, ec_a, ev_a, fv_a}), 32'd0);
      @(negedge clk) rst = 1'b0;
      for (int t = 0; t < 5; t++) begin
         @(negedge clk);
         chk($sformatf("post-rst idle %0d", t), 32'({vec_a, busy_a, done_a, ec_a}), 32'd0);
      end

      // Continuous parity sweeps; truth table switches at each sweep boundary
      tt_seq[0] = 16'h6996;
      tt_seq[1] = 16'h6996 ^ (16'd1 << $urandom_range(15, 0));
      tt_seq[2] = 16'($urandom);
      tt_seq[3] = 16'h6996;
      tt_seq[4] = 16'h6996;
      tt_b = tt_seq[0];
      @(negedge clk) start_b = 1'b1;
      @(negedge clk) start_b = 1'b0;
      for (int t = 1; t <= 65; t++) begin
         p = (t - 1) % 16;
         s = (t - 1) / 16;
         if (t > 1 && p == 0)
            chk($sformatf("B pass sweep%0d", s - 1), 32'(pass_b), 32'(tt_seq[s-1] == 16'h6996));
         d = tt_seq[s] ^ 16'h6996;
         c = cnt_lt(d, p);
         chk($sformatf("B cyc%0d", t),
             32'({busy_b, done_b, vec_b, ec_b, ev_b, fv_b}),
             32'({1'b1, (t > 1 && p == 0), 4'(p), 5'(c), (c > 0), 4'(first_lt(d, p))}));
         if (p == 0) tt_b = tt_seq[s];
         start_b = (t == 20);
         @(negedge clk);
      end
      start_b = 1'b0;
      abort_b = 1'b1;
      @(negedge clk) abort_b = 1'b0;
      chk("B abort", 32'({busy_b, done_b, vec_b}), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/exhaustive_vector_checker.md
# exhaustive_vector_checker

Parametrised, synthesizable successor to our fixed 3-input exhaustive testbench. It drives every input combination of an N-input combinational DUT in ascending binary order and holds each vector for a programmable number of clocks. On the last hold cycle it samples the DUT output and compares it against a golden truth table, counting mismatches and capturing the first failing vector. It sits beside the DUT on the lab board/bench, replacing hand-written `#100` stimulus lists, and supports one-shot and continuous sweep modes.

## Interface
- `N`, 3: number of DUT inputs, 1..8.
- `HOLD`, 4: clocks each vector is held, ≥1.
- `EXPECTED`, 8'b1110_1000: 2^N-bit golden truth table; bit i is the expected f for vec == i. Default is 3-input majority.
- `CONTINUOUS`, 0: 0 = single sweep then DONE; 1 = restart automatically after each sweep.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begins a sweep; acted on in IDLE or DONE only.
- `abort`  in  1  returns to IDLE from any state; priority over `start`.
- `f_dut`  in  1  DUT output.
- `vec`  out  N  vector driven to DUT inputs.
- `busy`  out  1  high while in APPLY.
- `done`  out  1  high in DONE (one-shot); one-cycle pulse per completed sweep (continuous).
- `pass`  out  1  valid when `done`; 1 iff `err_count` == 0.
- `err_count`  out  N+1  mismatches in the current/last sweep.
- `err_valid`  out  1  at least one mismatch captured this sweep.
- `first_err_vec`  out  N  first mismatching vector of the sweep.

## Operation
- States: IDLE, APPLY, DONE.
- Reset (async): state=IDLE; `vec`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `err_valid`=0, `first_err_vec`=0, hold counter=0.
- IDLE: on `start`, go to APPLY. Set `vec`=0, hold counter=0, clear `err_count`, `err_valid`, `first_err_vec`, `done`, `pass`.
- APPLY:
  - Hold counter runs 0..HOLD-1.
  - At HOLD-1 (sample cycle), compare `f_dut` with `EXPECTED[vec]`. On mismatch, increment `err_count`. If `err_valid` was 0, also load `first_err_vec`=`vec` and set `err_valid`.
  - After the sample, if `vec` < 2^N-1: `vec`+1, counter=0.
  - If `vec` == 2^N-1: one-shot goes to DONE. Continuous pulses `done` and updates `pass` from the final count, including the last sample, then behaves as a fresh `start`: counts cleared, `vec`=0.
- DONE: `vec` holds the last vector; `done`=1; `pass` held. `start` restarts exactly as from IDLE.
- `abort` (any state): go to IDLE. `busy`=0, `done`=0, `vec`=0. Error registers keep their values.
- `start` in APPLY is ignored.
- Width rule: `err_count` is N+1 bits, so 2^N errors are representable without saturation.

## Timing
- `start` sampled high at edge k: `busy`=1 and `vec`=0 from k+1.
- Vector i is presented for cycles k+1+i·HOLD through k+(i+1)·HOLD.
- `f_dut` is sampled at the last of those cycles. The DUT has HOLD-1 cycles of settling margin; with HOLD=1, a combinational same-cycle response is required.
- One-shot: `busy` falls and `done`/`pass` rise at k+2^N·HOLD+1. Total sweep is 2^N·HOLD cycles.
- Continuous: the `done` pulse is on cycle k+2^N·HOLD+1, the same cycle `vec` returns to 0.
- `err_count`/`err_valid` update the cycle after the sample edge.
- `abort` and `start` asserted together: `abort` wins, and the block ends in IDLE.

## Test plan
- Default params, DUT = correct majority, `start` at cycle 2 → `vec` steps 0..7 every 4 cycles; `done`=1, `pass`=1, `err_count`=0 at cycle 35.
- DUT = majority with output forced 1 at inputs 3'b001 and 3'b100 → `err_count`=2, `err_valid`=1, `first_err_vec`=3'b001, `pass`=0.
- DUT = constant 0 → `err_count`=4, `first_err_vec`=3'b011.
- `abort` during `vec`=5 → next cycle IDLE, `busy`=0, `vec`=0. A later `start` clears counts and a full sweep passes.
- `rst` pulsed mid-sweep and between clock edges → all outputs zero immediately, no further vector changes until `start`.
- N=4, HOLD=1, CONTINUOUS=1, EXPECTED=16'h6996 (parity) with a parity DUT → `done` pulses every 16 cycles, `pass`=1 each pulse, and `start` during the sweep has no effect.
